drr_input_arbiter: RTL and testbench

Deficit-round-robin scheduler that merges NUM_QUEUES packet input FIFOs into the single 64-bit user datapath, in place of the packet-count round-robin input arbiter. Fairness is in bytes, not packets, so queues carrying small packets no longer get more than their share. It sits between the rx queue FIFOs and the first pipeline stage (output port lookup). Each queue's per-packet charge comes from the byte-length field of the module header.

---
 rtl/drr_input_arbiter_pkg.sv | 34 +++
 rtl/drr_credit_bank.sv | 49 ++++
 rtl/drr_input_arbiter.sv | 147 ++++++++++++++
 tb/tb_drr_input_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drr_input_arbiter_pkg.sv
// Shared definitions for the deficit-round-robin input arbiter: IOQ header
// layout, FSM state encoding and credit-bank operation codes.
package drr_input_arbiter_pkg;

  localparam logic [7:0] IOQ_HDR_CTRL  = 8'hFF;
  localparam int         HDR_LEN_MSB   = 15;
  localparam int         HDR_LEN_LSB   = 0;
  localparam int         HDR_LEN_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XMIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    CR_NOP   = 2'd0,
    CR_CLEAR = 2'd1,
    CR_ADD   = 2'd2,
    CR_SUB   = 2'd3
  } credit_op_e;

  // Byte charge for a head word: only module headers carry a length.
  function automatic logic [HDR_LEN_WIDTH-1:0] hdr_len(
    input logic [HDR_LEN_WIDTH-1:0] len_field,
    input logic [7:0]               ctrl
  );
    if (ctrl == IOQ_HDR_CTRL) begin
      return len_field;
    end else begin
      return 16'd0;
    end
  endfunction

endpackage

// File: rtl/drr_credit_bank.sv
// Per-queue deficit counters with a single selected port: clear, saturating
// quantum credit, or length debit, plus a combinational read of the selected entry.
module drr_credit_bank
  import drr_input_arbiter_pkg::*;
#(
  parameter int  NUM_QUEUES    = 8,
  parameter int  QUANTUM       = 1600,
  parameter int  DEFICIT_WIDTH = 17,
  localparam int QW            = $clog2(NUM_QUEUES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [QW-1:0]            sel_i,
  input  credit_op_e               op_i,
  input  logic [DEFICIT_WIDTH-1:0] len_i,
  output logic [DEFICIT_WIDTH-1:0] deficit_o
);

  logic [DEFICIT_WIDTH-1:0] deficit_q [NUM_QUEUES];
  logic [DEFICIT_WIDTH:0]   sum_s;
  logic [DEFICIT_WIDTH-1:0] deficit_d;

  assign deficit_o = deficit_q[sel_i];

  // Next value of the selected counter; the credit saturates at all-ones.
  always_comb begin
    sum_s     = {1'b0, deficit_o} + (DEFICIT_WIDTH+1)'(QUANTUM);
    deficit_d = deficit_o;
    case (op_i)
      CR_CLEAR: deficit_d = {DEFICIT_WIDTH{1'b0}};
      CR_ADD:   deficit_d = sum_s[DEFICIT_WIDTH] ? {DEFICIT_WIDTH{1'b1}}
                                                 : sum_s[DEFICIT_WIDTH-1:0];
      CR_SUB:   deficit_d = deficit_o - len_i;
      default:  deficit_d = deficit_o;
    endcase
  end

  // Counter storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        deficit_q[i] <= {DEFICIT_WIDTH{1'b0}};
      end
    end else if (op_i != CR_NOP) begin
      deficit_q[sel_i] <= deficit_d;
    end
  end

endmodule

// File: rtl/drr_input_arbiter.sv
// Deficit-round-robin merge of NUM_QUEUES first-word-fall-through packet FIFOs
// onto one registered datapath; fairness is measured in header byte lengths.
module drr_input_arbiter
  import drr_input_arbiter_pkg::*;
#(
  parameter int  DATA_WIDTH    = 64,
  parameter int  CTRL_WIDTH    = DATA_WIDTH/8,
  parameter int  NUM_QUEUES    = 8,
  parameter int  QUANTUM       = 1600,
  parameter int  DEFICIT_WIDTH = 17,
  localparam int QW            = $clog2(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_empty,
  output logic [NUM_QUEUES-1:0]            in_rd_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [QW-1:0]                    cur_queue
);

  arb_state_e               state_q, state_d;
  logic [QW-1:0]            q_q, q_d;
  logic                     new_visit_q, new_visit_d;
  logic [CTRL_WIDTH-1:0]    prev_ctrl_q, prev_ctrl_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]    out_ctrl_q, out_ctrl_d;
  logic                     out_wr_q, out_wr_d;

  logic [DATA_WIDTH-1:0]    head_data_s;
  logic [CTRL_WIDTH-1:0]    head_ctrl_s;
  logic                     head_empty_s;
  logic [HDR_LEN_WIDTH-1:0] hdr_len_s;
  logic [DEFICIT_WIDTH-1:0] len_ext_s;
  logic [DEFICIT_WIDTH-1:0] deficit_s;
  logic [QW-1:0]            q_next_s;
  logic                     fits_s;
  logic                     go_s;
  logic                     pop_s;
  credit_op_e               credit_op_s;

  assign head_data_s  = in_data[q_q*DATA_WIDTH +: DATA_WIDTH];
  assign head_ctrl_s  = in_ctrl[q_q*CTRL_WIDTH +: CTRL_WIDTH];
  assign head_empty_s = in_empty[q_q];
  assign hdr_len_s    = hdr_len(head_data_s[HDR_LEN_MSB:HDR_LEN_LSB], head_ctrl_s);
  assign len_ext_s    = {{(DEFICIT_WIDTH-HDR_LEN_WIDTH){1'b0}}, hdr_len_s};
  assign fits_s       = (len_ext_s <= deficit_s);
  assign q_next_s     = (q_q == QW'(NUM_QUEUES-1)) ? {QW{1'b0}} : q_q + QW'(1);
  // Nothing is popped while reset is held so no word is lost on the way out.
  assign go_s         = out_rdy & ~reset;

  drr_credit_bank #(
    .NUM_QUEUES    (NUM_QUEUES),
    .QUANTUM       (QUANTUM),
    .DEFICIT_WIDTH (DEFICIT_WIDTH)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .sel_i     (q_q),
    .op_i      (credit_op_s),
    .len_i     (len_ext_s),
    .deficit_o (deficit_s)
  );

  // Scheduling decision and packet forwarding.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    new_visit_d = new_visit_q;
    credit_op_s = CR_NOP;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          if (head_empty_s) begin
            credit_op_s = CR_CLEAR;
            q_d         = q_next_s;
            new_visit_d = 1'b1;
          end else if (new_visit_q) begin
            credit_op_s = CR_ADD;
            new_visit_d = 1'b0;
          end else if (fits_s) begin
            credit_op_s = CR_SUB;
            pop_s       = 1'b1;
            state_d     = ST_XMIT;
          end else begin
            q_d         = q_next_s;
            new_visit_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XMIT: begin
        if (go_s && !head_empty_s) begin
          pop_s = 1'b1;
          // End of packet: non-zero ctrl right after a payload (zero-ctrl) word.
          if ((head_ctrl_s != {CTRL_WIDTH{1'b0}}) && (prev_ctrl_q == {CTRL_WIDTH{1'b0}})) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_XMIT;
          end
        end else begin
          state_d = ST_XMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign prev_ctrl_d = pop_s ? head_ctrl_s : prev_ctrl_q;
  assign out_wr_d    = pop_s;
  assign out_data_d  = pop_s ? head_data_s : out_data_q;
  assign out_ctrl_d  = pop_s ? head_ctrl_s : out_ctrl_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      q_q         <= {QW{1'b0}};
      new_visit_q <= 1'b1;
      prev_ctrl_q <= {CTRL_WIDTH{1'b0}};
      out_data_q  <= {DATA_WIDTH{1'b0}};
      out_ctrl_q  <= {CTRL_WIDTH{1'b0}};
      out_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      new_visit_q <= new_visit_d;
      prev_ctrl_q <= prev_ctrl_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      out_wr_q    <= out_wr_d;
    end
  end

  assign in_rd_en  = pop_s ? (NUM_QUEUES'(1) << q_q) : {NUM_QUEUES{1'b0}};
  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_wr    = out_wr_q;
  assign cur_queue = q_q;

endmodule

// File: tb/tb_drr_input_arbiter.sv
// Self-checking bench: randomised traffic into modelled FIFOs, checked against a
// packet-level deficit-round-robin reference computed from the scheduling rules.
module tb_drr_input_arbiter;
  import drr_input_arbiter_pkg::*;

  localparam int NQ      = 8;
  localparam int QUANTUM = 1600;
  localparam int DMAX    = (1 << 17) - 1;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    bit          last;
    int          q;
    int          def;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [NQ*64-1:0] in_data;
  logic [NQ*8-1:0] in_ctrl;
  logic [NQ-1:0]   in_empty;
  logic [NQ-1:0]   in_rd_en;
  logic [63:0]     out_data;
  logic [7:0]      out_ctrl;
  logic            out_wr;
  logic            out_rdy;
  logic [2:0]      cur_queue;

  logic [71:0] fifo [NQ][$];
  int          m_len [NQ][$];
  int          m_nw  [NQ][$];
  exp_t        exp_w [$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;
  int   stall_qi = -1;
  int   stall_left = 0;
  int   stall_pops = 0;
  int   npops = 0;
  bit   popped;
  bit   stalled;
  logic [NQ-1:0] rd;

  drr_input_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_wr    (out_wr),
    .out_rdy   (out_rdy),
    .cur_queue (cur_queue)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NQ; i++) begin
      fifo[i].delete();
      m_len[i].delete();
      m_nw[i].delete();
    end
    exp_w.delete();
    stall_qi   = -1;
    stall_left = 0;
    stall_pops = 0;
  endtask

  task automatic add_pkt(input int q, input int len);
    int nw;
    logic [7:0] eop;
    nw  = (len + 7) / 8;
    if (nw < 2) nw = 2;
    eop = 8'h80 >> ((len - 1) % 8);
    fifo[q].push_back({8'hFF, 16'($urandom), 32'($urandom), 16'(len)});
    for (int k = 1; k <= nw; k++) begin
      fifo[q].push_back({(k == nw) ? eop : 8'h00, 32'($urandom), 32'($urandom)});
    end
    m_len[q].push_back(len);
    m_nw[q].push_back(nw + 1);
  endtask

  // Classic DRR over whole packets: each visit credits a quantum, sends while the
  // head fits, and forfeits the deficit once the queue runs dry.
  task automatic build_expect();
    logic [71:0] snap [NQ][$];
    int def [NQ];
    int left, q, len, nw;
    exp_t e;
    left = 0;
    for (int i = 0; i < NQ; i++) begin
      snap[i] = fifo[i];
      def[i]  = 0;
      left   += m_len[i].size();
    end
    q = 0;
    while (left > 0) begin
      if (m_len[q].size() > 0) begin
        def[q] = (def[q] + QUANTUM > DMAX) ? DMAX : def[q] + QUANTUM;
        while (m_len[q].size() > 0 && m_len[q][0] <= def[q]) begin
          len    = m_len[q].pop_front();
          nw     = m_nw[q].pop_front();
          def[q] = def[q] - len;
          for (int k = 0; k < nw; k++) begin
            {e.ctrl, e.data} = snap[q].pop_front();
            e.last = (k == nw - 1);
            e.q    = q;
            e.def  = def[q];
            exp_w.push_back(e);
          end
          left--;
        end
      end
      if (m_len[q].size() == 0) def[q] = 0;
      q = (q + 1) % NQ;
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < NQ; i++) begin
      in_empty[i] = (fifo[i].size() == 0) || (stall_left > 0 && i == stall_qi);
      in_data[i*64 +: 64] = (fifo[i].size() > 0) ? fifo[i][0][63:0] : 64'd0;
      in_ctrl[i*8 +: 8]   = (fifo[i].size() > 0) ? fifo[i][0][71:64] : 8'd0;
    end
    stalled = (stall_left > 0);
    if (stall_left > 0) stall_left--;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ($urandom_range(0, 3) != 0);
      default: out_rdy = ~out_rdy;
    endcase
    #1;
    rd = in_rd_en;
    check_eq("rd_onehot", 64'($countones(rd) <= 1), 64'd1);
    check_eq("rd_without_rdy", 64'((rd != 0) && !out_rdy), 64'd0);
    check_eq("rd_empty", 64'(rd & in_empty), 64'd0);
    @(posedge clk);
    popped = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      if (rd[i] && fifo[i].size() > 0) begin
        void'(fifo[i].pop_front());
        popped = 1'b1;
        npops++;
        if (i == stall_qi) begin
          stall_pops++;
          if (stall_pops == 3) stall_left = 5;
        end
      end
    end
    @(negedge clk);
    check_eq("wr_latency", 64'(out_wr), 64'(popped));
    check_eq("wr_without_rdy", 64'(out_wr && !out_rdy), 64'd0);
  endtask

  task automatic check_out();
    exp_t w;
    if (out_wr) begin
      if (exp_w.size() == 0) begin
        check_eq("extra_wr", 64'd1, 64'd0);
      end else begin
        w = exp_w.pop_front();
        check_eq("out_data", out_data, w.data);
        check_eq("out_ctrl", 64'(out_ctrl), 64'(w.ctrl));
        if (w.last) begin
          check_eq("pkt_queue", 64'(cur_queue), 64'(w.q));
          check_eq("pkt_deficit", 64'(dut.u_bank.deficit_q[w.q]), 64'(w.def));
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush();
    rdy_mode = 0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic run_traffic(input int mode);
    int budget, n;
    build_expect();
    budget   = 4 * exp_w.size() + 400;
    n        = 0;
    rdy_mode = mode;
    while (exp_w.size() > 0 && n < budget) begin
      cycle();
      check_out();
      if (stalled) begin
        check_eq("stall_wr", 64'(out_wr), 64'd0);
        check_eq("stall_state", 64'(dut.state_q), 64'(ST_XMIT));
      end
      n++;
    end
    check_eq("words_left", 64'(exp_w.size()), 64'd0);
    rdy_mode = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      check_out();
    end
    for (int i = 0; i < NQ; i++) begin
      check_eq("drained_deficit", 64'(dut.u_bank.deficit_q[i]), 64'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    out_rdy  = 1'b1;
    in_empty = '1;
    in_data  = '0;
    in_ctrl  = '0;
    do_reset();
    reset = 1'b1;
    cycle();
    check_eq("rst_out_wr", 64'(out_wr), 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("rst_cur_queue", 64'(cur_queue), 64'd0);
    reset = 1'b0;

    // Idle sweep: pointer advances once per cycle and wraps.
    for (int k = 1; k <= 20; k++) begin
      cycle();
      check_eq("idle_wr", 64'(out_wr), 64'd0);
      check_eq("idle_cur_queue", 64'(cur_queue), 64'(k % NQ));
    end
    for (int i = 0; i < NQ; i++) begin
      check_eq("idle_deficit", 64'(dut.u_bank.deficit_q[i]), 64'd0);
    end

    // Big versus small packets: byte fairness.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      add_pkt(0, 1500);
      add_pkt(1, 64);
    end
    run_traffic(1);

    // One busy queue of small packets: 25 per quantum.
    do_reset();
    for (int k = 0; k < 30; k++) add_pkt(2, 64);
    run_traffic(0);

    // 9-word packet with out_rdy toggling each cycle.
    do_reset();
    add_pkt(5, 64);
    run_traffic(2);

    // Queue 3 runs dry mid-packet for 5 cycles.
    do_reset();
    add_pkt(3, 100);
    stall_qi = 3;
    run_traffic(0);

    // Random mixes.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < NQ; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int k = 0; k < np; k++) add_pkt(i, $urandom_range(16, 1600));
      end
      run_traffic(1);
    end

    // Reset mid-packet.
    do_reset();
    add_pkt(4, 400);
    npops = 0;
    for (int k = 0; k < 200 && npops < 10; k++) cycle();
    check_eq("mid_pkt_reached", 64'(npops >= 10), 64'd1);
    reset = 1'b1;
    cycle();
    check_eq("midrst_out_wr", 64'(out_wr), 64'd0);
    check_eq("midrst_cur_queue", 64'(cur_queue), 64'd0);
    check_eq("midrst_state", 64'(dut.state_q), 64'(ST_IDLE));
    for (int i = 0; i < NQ; i++) begin
      check_eq("midrst_deficit", 64'(dut.u_bank.deficit_q[i]), 64'd0);
    end
    reset = 1'b0;
    flush();
    add_pkt(0, 64);
    add_pkt(1, 200);
    run_traffic(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
